// File: rtl/int_to_float_conv_if.sv
// Operand/result handshake bundle between an integer producer, the converter and the FPU-side consumer.
interface int_to_float_conv_if;
    logic [31:0] int_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  status_out;

    modport master (
        output int_in, in_valid, out_ready,
        input  in_ready, data_out, out_valid, status_out
    );

    modport slave (
        input  int_in, in_valid, out_ready,
        output in_ready, data_out, out_valid, status_out
    );
endinterface

// File: rtl/int_to_float_conv.sv
// Signed 32-bit integer to FPU operand format {sign, exp[5:0] bias 31, mant[24:0]} with round-to-nearest-even.
// Build option INT2F_FAST_NORM_EN: single-cycle leading-zero normalisation instead of one bit per cycle.
module int_to_float_conv (
    input  logic                      clock,
    input  logic                      reset,
    int_to_float_conv_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] ST_EXACT   = 4'b0001;
    localparam logic [3:0] ST_INEXACT = 4'b1000;
    localparam logic [5:0] EXP_TOP    = 6'd62;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [5:0]  exp_q, exp_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  status_q, status_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    logic [31:0] abs_in;
    logic [24:0] mant_raw;
    logic        guard_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [25:0] mant_sum;
    logic [5:0]  exp_rnd;

`ifdef INT2F_FAST_NORM_EN
    // Leading-zero count of a nonzero magnitude (0..31).
    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && v[i]) begin
                found = 1'b1;
            end else if (!found) begin
                n = n + 5'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic [4:0] lz_cnt;
    assign lz_cnt = lzc32(mag_q);
`endif

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign abs_in     = bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;
    assign mant_raw   = mag_q[30:6];
    assign guard_bit  = mag_q[5];
    assign sticky_bit = |mag_q[4:0];
    assign round_up   = guard_bit & (sticky_bit | mant_raw[0]);
    assign mant_sum   = {1'b0, mant_raw} + {25'd0, round_up};
    assign exp_rnd    = exp_q + {5'd0, mant_sum[25]};

    // Next-state and datapath for the conversion FSM.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        data_d   = data_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.int_in[31];
                    mag_d  = abs_in;
                    exp_d  = EXP_TOP;
                    if (abs_in == 32'd0) begin
                        data_d   = 32'd0;
                        status_d = ST_EXACT;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_NORM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_NORM: begin
`ifdef INT2F_FAST_NORM_EN
                mag_d   = mag_q << lz_cnt;
                exp_d   = exp_q - {1'b0, lz_cnt};
                state_d = S_ROUND;
`else
                if (mag_q[31]) begin
                    state_d = S_ROUND;
                end else begin
                    mag_d = {mag_q[30:0], 1'b0};
                    exp_d = exp_q - 6'd1;
                end
`endif
            end
            S_ROUND: begin
                // A carry out of the mantissa leaves mant_sum[24:0] at zero.
                data_d   = {sign_q, exp_rnd, mant_sum[24:0]};
                status_d = (guard_bit | sticky_bit) ? ST_INEXACT : ST_EXACT;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            mag_q       <= 32'd0;
            exp_q       <= 6'd0;
            data_q      <= 32'd0;
            status_q    <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            data_q      <= data_d;
            status_q    <= status_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.data_out   = data_q;
    assign bus.status_out = status_q;

endmodule

// File: tb/tb_int_to_float_conv.sv
// Directed-vector bench for int_to_float_conv: results, status, latency, backpressure and reset abort.
module tb_int_to_float_conv;

    logic clock;
    logic reset;
    int   err_cnt;
    int   chk_cnt;

    int_to_float_conv_if bus ();

    int_to_float_conv dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef INT2F_FAST_NORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam logic [3:0] ST_EXACT   = 4'b0001;
    localparam logic [3:0] ST_INEXACT = 4'b1000;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // lz = leading zeros of |val|; hold = cycles of out_ready=0 in DONE with in_valid pulses.
    task automatic convert(input logic [31:0] val, input logic [31:0] exp_data,
                           input logic [3:0] exp_stat, input int lz, input int hold);
        int   lat;
        int   want;
        logic seen;
        if (val == 32'd0) want = 1;
        else want = FAST ? 2 : lz + 2;
        for (int i = 0; i < 10 && !bus.in_ready; i++) begin
            @(posedge clock); #1;
        end
        check_val($sformatf("in_ready_before %h", val), {31'd0, bus.in_ready}, 32'd1);
        bus.int_in   = val;
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.int_in   = 32'hDEAD_BEEF;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clock); #1;
            lat++;
            seen = bus.out_valid;
        end
        check_val($sformatf("latency %h", val), lat, want);
        check_val($sformatf("data %h", val), bus.data_out, exp_data);
        check_val($sformatf("status %h", val), {28'd0, bus.status_out}, {28'd0, exp_stat});
        check_val($sformatf("in_ready_busy %h", val), {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.int_in   = 32'h1234_5678;
            @(posedge clock); #1;
            check_val("hold_data", bus.data_out, exp_data);
            check_val("hold_status", {28'd0, bus.status_out}, {28'd0, exp_stat});
            check_val("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check_val("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check_val("release_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("idle_data_held", bus.data_out, exp_data);
    endtask

    initial begin
        int stray;
        err_cnt       = 0;
        chk_cnt       = 0;
        reset         = 1'b1;
        bus.int_in    = 32'd0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("rst_data", bus.data_out, 32'd0);
        check_val("rst_status", {28'd0, bus.status_out}, 32'd0);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clock); #1;

        convert(32'h0000_0001, 32'h3E00_0000, ST_EXACT,   31, 0);
        convert(32'hFFFF_FFFE, 32'hC000_0000, ST_EXACT,   30, 0);
        convert(32'h0000_000A, 32'h4480_0000, ST_EXACT,   28, 0);
        convert(32'hFFFF_FFF6, 32'hC480_0000, ST_EXACT,   28, 0);
        convert(32'h0000_0000, 32'h0000_0000, ST_EXACT,    0, 0);
        convert(32'h7FFF_FFFF, 32'h7C00_0000, ST_INEXACT,  1, 0);
        convert(32'h8000_0000, 32'hFC00_0000, ST_EXACT,    0, 0);
        convert(32'h4000_0010, 32'h7A00_0000, ST_INEXACT,  1, 0);
        convert(32'h4000_0030, 32'h7A00_0002, ST_INEXACT,  1, 0);
        convert(32'h4000_0011, 32'h7A00_0001, ST_INEXACT,  1, 0);
        convert(32'h4000_0001, 32'h7A00_0000, ST_INEXACT,  1, 0);
        convert(32'h0000_000A, 32'h4480_0000, ST_EXACT,   28, 5);

        // Abort a conversion of 1 while it is normalising.
        bus.int_in   = 32'h0000_0001;
        bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clock); #1;
        reset        = 1'b0;
        check_val("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("abort_data", bus.data_out, 32'd0);
        check_val("abort_status", {28'd0, bus.status_out}, 32'd0);
        check_val("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.out_valid) stray++;
        end
        check_val("abort_no_result", stray, 32'd0);
        convert(32'h0000_000A, 32'h4480_0000, ST_EXACT, 28, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/int_to_float_conv.md
INT_TO_FLOAT_CONV -- requirements
Module: int_to_float_conv

Interface
REQ-001 SHALL have one clock and synchronous active-high reset.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-004 int_in  in  32  signed two's-complement integer operand.
REQ-005 in_valid  in  1  int_in valid this cycle.
REQ-006 in_ready  out  1  converter idle, accepts operand.
REQ-007 data_out  out  32  result in FPU operand format {sign[31], exp[30:25] bias 31, mantissa[24:0] hidden-1}; directly drives FPU op_A_in/op_B_in.
REQ-008 out_valid  out  1  data_out/status_out valid.
REQ-009 out_ready  in  1  consumer takes result.
REQ-010 status_out  out  4  one-hot: [0] EXACT, [1] OVERFLOW, [2] UNDERFLOW, [3] INEXACT; same encoding as FPU status_out.

Function
REQ-011 SHALL implement FSM IDLE, NORM, ROUND, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-012 Accept edge: in IDLE with in_valid=1, SHALL capture sign=int_in[31], mag=|int_in| as 32-bit unsigned (0x80000000 -> mag 0x80000000), exp=62.
REQ-013 On accept, mag==0 -> DONE with data_out=0x00000000, status_out=EXACT (sign ignored, no -0); else -> NORM.
REQ-014 NORM, mag[31]==0: shift mag left 1, exp -= 1, stay; mag[31]==1: -> ROUND.
REQ-015 ROUND: mant=mag[30:6], guard=mag[5], sticky=|mag[4:0]; round-to-nearest-even (up if guard & (sticky | mant[0])).
REQ-016 Round carry out of mant (all ones + 1): mant=0, exp += 1; exp never exceeds 62.
REQ-017 ROUND -> DONE loading data_out={sign,exp,mant}; status_out=INEXACT if guard|sticky, else EXACT.
REQ-018 OVERFLOW and UNDERFLOW bits SHALL always be 0 (range 2^0..2^31 fits exp 31..62).
REQ-019 Latency: nonzero with k leading zeros of mag -> out_valid rises k+2 edges after accept edge; zero -> 1 edge.
REQ-020 DONE: data_out, status_out stable while out_valid=1 & out_ready=0; out_ready=1 -> IDLE next edge, out_valid drops.
REQ-021 in_valid outside IDLE SHALL be ignored; no queuing; next accept earliest edge after DONE exit.
REQ-022 data_out/status_out hold last result in IDLE; registered outputs only.

Reset
REQ-023 reset=1 at edge SHALL force IDLE, data_out=0, status_out=0, out_valid=0, internal mag/exp/sign=0, in_ready=1 after that edge.
REQ-024 Reset mid-conversion (NORM/ROUND/DONE) SHALL discard operand; no out_valid for it.
REQ-025 Reset has priority over in_valid and out_ready on same edge.

Configuration
REQ-026 Macro INT2F_FAST_NORM_EN defined: NORM SHALL complete in one cycle (leading-zero count, single barrel shift, exp=62-k) then ROUND; nonzero latency fixed 2 edges.
REQ-027 INT2F_FAST_NORM_EN undefined: one-bit-per-cycle shifting per REQ-014; results bit-identical in both builds.

Verification
REQ-028 int_in=1 -> data_out=0x3E000000, status EXACT, out_valid 33 edges after accept (2 with INT2F_FAST_NORM_EN).
REQ-029 int_in=-2 -> 0xC0000000 EXACT; int_in=10 -> 0x44800000 EXACT; int_in=0 -> 0x00000000 EXACT after 1 edge.
REQ-030 int_in=0x7FFFFFFF -> 0x7C000000, INEXACT (round carry); int_in=0x80000000 -> 0xFC000000 EXACT.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> data_out/status_out stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-032 Reset asserted during NORM of int_in=1 -> next edge out_valid=0, data_out=0, in_ready=1; fresh int_in=10 converts to 0x44800000.
